// File: rtl/sic1_out_fifo.sv
// sic1_out_fifo: byte output buffer between the SIC1 memory output port and the host.
// Captures every strobed byte into a DEPTH-entry FIFO and presents it first-word
// fall-through over a valid/ready handshake. It raises almost_full early so the core
// can stall.
// Optional feature: define SIC1_OUT_FIFO_OVF_EN to build the sticky overflow flag.
// Without it, ovf is tied low and full pushes are dropped without any record.

module sic1_out_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_byte,
    input  logic                     in_strobe,
    input  logic                     flush,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, push_en, pop_en;

    // Handshake decode; occupancy, not pointer equality, decides full/empty.
    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        pop_en  = !empty && out_ready;
        // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
        push_en = in_strobe && (!full || pop_en) && !flush;
    end

    // Next-state for pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= in_byte;
    end

    // Outputs are decoded from registered state only, so there is no push-to-pop bypass.
    always_comb begin
        out_valid   = !empty;
        out_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
        count       = count_q;
        almost_full = (count_q >= AF_CNT);
    end

`ifdef SIC1_OUT_FIFO_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_event;

    // Sticky overflow; a set event in the same cycle as ovf_clr wins.
    always_comb begin
        ovf_event = in_strobe && full && !pop_en && !flush;
        ovf_d     = ovf_q;
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sic1_out_fifo.sv
// Self-checking bench for sic1_out_fifo (DEPTH=8, AF_MARGIN=2).
// It uses a vector table of per-cycle inputs and the outputs expected after the edge.
// A byte scoreboard checks data order on every pop.
// Hand-written sequences cover streaming wrap, flush, ovf_clr versus set, and async reset.

module tb_sic1_out_fifo;

    localparam int unsigned DEPTH = 8;

`ifdef SIC1_OUT_FIFO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_byte;
    logic       in_strobe;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       almost_full;
    logic       ovf;
    logic       ovf_clr;

    sic1_out_fifo #(
        .DEPTH     (DEPTH),
        .AF_MARGIN (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_strobe   (in_strobe),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q[$];

    typedef struct {
        logic       s;
        logic [7:0] b;
        logic       r;
        logic       f;
        logic       c;
        logic [3:0] cnt;
        logic       v;
        logic [7:0] d;
        logic       af;
        logic       ovf;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge. It drives one cycle and updates the scoreboard
    // before the rising edge, then returns at the next falling edge.
    task automatic cycle(input logic s, input logic [7:0] b, input logic r,
                         input logic f, input logic c);
        logic mpop;
        in_strobe = s;
        in_byte   = b;
        out_ready = r;
        flush     = f;
        ovf_clr   = c;
        #1;
        chk("sb_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        mpop = (sb_q.size() != 0) && r;
        if (f) begin
            sb_q.delete();
        end else begin
            if (mpop) begin
                chk("sb_data", 32'(out_data), 32'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (s && (sb_q.size() < DEPTH)) sb_q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // s  byte   r  f  c  cnt v  data   af ovf
        vecs[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 8'h48, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h49, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 8'h48, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'h49, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        for (int k = 1; k <= 8; k++) begin
            vecs[3+k] = '{1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 4'(k), 1'b1, 8'h01,
                          (k >= 6), 1'b0};
        end
        vecs[12] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1, 8'h02, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 8'h03, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 8'h04, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 8'h05, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 8'h06, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 8'h08, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'hAA, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst       = 1'b1;
        in_byte   = 8'h00;
        in_strobe = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Basic push/pop, fill to full, dropped push, full push+pop, drain, ovf clear.
        for (int i = 0; i < 23; i++) begin
            cycle(vecs[i].s, vecs[i].b, vecs[i].r, vecs[i].f, vecs[i].c);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].d));
            chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(vecs[i].af));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf & OVF_EN));
        end

        // Sustained push+pop; write pointer wraps past 7 more than once.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("stream_drain_count", 32'(count), 32'd0);

        // Fill, then overflow coincident with ovf_clr: set wins.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("setwins_ovf", 32'(ovf), 32'(OVF_EN));
        chk("setwins_count", 32'(count), 32'd8);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 32'd5);
        chk("preflush_head", 32'(out_data), 32'h13);

        // Flush with a simultaneous push: push is dropped, not an overflow.
        cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'h00);
        chk("flush_ovf", 32'(ovf), 32'(OVF_EN));
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("postflush_head", 32'(out_data), 32'h5A);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        chk("prerst_count", 32'(count), 32'd3);

        // Asynchronous reset mid-cycle; outputs must clear before the next rising edge.
        in_strobe = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'h00);
        chk("arst_af", 32'(almost_full), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("postrst_head", 32'(out_data), 32'h77);
        chk("postrst_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sic1_out_fifo.md
# sic1_out_fifo

Output buffer for the SIC1 core. It sits directly downstream of the memory block's output-port logic and captures every byte written to the output address (`uo_out`/`out_strobe`) into a small FIFO. It drains those bytes to the host over a valid/ready handshake and raises a stall request before it fills, so the core can pause instead of losing output.

## Interface

Parameters:
- `DEPTH`, 8: number of byte entries; power of two, at least 2.
- `AF_MARGIN`, 2: `almost_full` asserts when free entries ≤ `AF_MARGIN`; range 0 to `DEPTH`-1.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_byte` input 8: byte to capture; connects to the memory's `uo_out`.
- `in_strobe` input 1: push request; connects to the memory's `out_strobe`. Each cycle it is high is one byte.
- `flush` input 1: synchronous clear of the FIFO contents.
- `out_data` output 8: head byte; valid only while `out_valid`=1.
- `out_valid` output 1: FIFO is not empty.
- `out_ready` input 1: host accepts `out_data` this cycle.
- `count` output $clog2(DEPTH)+1: current occupancy, 0 to `DEPTH`.
- `almost_full` output 1: stall request to the core.
- `ovf` output 1: sticky overflow flag (see Configuration).
- `ovf_clr` input 1: clears `ovf`.

## Operation

- Storage is a register array of `DEPTH`×8, addressed by write and read pointers of $clog2(DEPTH) bits, plus an occupancy counter.
- Pointers wrap modulo `DEPTH` with natural binary rollover. Full and empty are derived from `count`, never from pointer equality.
- Push: `in_strobe`=1 and the FIFO is not full. Write `in_byte` at the write pointer, then increment the write pointer.
- Pop: `out_valid`=1 and `out_ready`=1. Increment the read pointer.
- `out_data` is the array entry at the read pointer (first-word fall-through, combinational from registers). When empty it reads 8'h00.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
- Push while full and popping in the same cycle: the push is accepted and `count` stays at `DEPTH`.
- Push while full and not popping: the byte is dropped, nothing changes, and an overflow event occurs.
- Push while empty: no bypass. The byte becomes visible on `out_data`/`out_valid` the next cycle, so a pop cannot happen in the push cycle.
- `almost_full` = (`count` ≥ `DEPTH`−`AF_MARGIN`). It is combinational from the registered `count`.
- `flush`:
  - Next edge: pointers and `count` go to 0.
  - It takes priority over a simultaneous push or pop. That push is dropped and is not an overflow.
  - `ovf` is unaffected.
- `out_ready` while empty has no effect.

## Timing

- Reset values: `count`=0, `out_valid`=0, `out_data`=8'h00, `almost_full`=0 (1 if `AF_MARGIN`≥`DEPTH`, which is disallowed), `ovf`=0. Pointers are 0. Array contents are don't-care.
- Reset asserted mid-operation clears the FIFO immediately (asynchronously). Bytes in flight are lost.
- Push-to-visible latency: 1 cycle. A strobe in cycle N gives `out_valid`=1 in cycle N+1.
- A pop in cycle N presents the next byte (or `out_valid`=0) in cycle N+1.
- `count` and `almost_full` reflect an edge's push/pop in the following cycle.
- Throughput: one push and one pop per cycle, sustained.
- Since the core's strobe is registered, `almost_full` reaches the core one cycle late. A margin of at least 2 absorbs the in-flight byte.

## Configuration

- Macro: `SIC1_OUT_FIFO_OVF_EN`.
- Defined:
  - An overflow event sets `ovf` on the next edge; `ovf` stays set until an edge with `ovf_clr`=1.
  - If an overflow event and `ovf_clr` occur in the same cycle, set wins.
- Undefined: `ovf` is tied to 0, `ovf_clr` is ignored, and no overflow logic is synthesized. Dropped bytes on full are silent.
- In both builds, FIFO data behaviour on a full push is identical: the byte is dropped.

## Test plan

- Reset, then push 8'h48, 8'h49 on consecutive cycles with `out_ready`=0.
  - Expected: `count`=2, `out_data`=8'h48, `out_valid`=1.
  - Then `out_ready`=1 for 2 cycles: 8'h48 then 8'h49 are popped, `out_valid`=0 after, `count`=0.
- Push 8 bytes 8'h01..8'h08 with `out_ready`=0 (DEPTH=8, AF_MARGIN=2).
  - Expected: `almost_full` rises in the cycle after the 6th push; `count`=8.
  - A 9th push of 8'hFF is dropped. With the macro, `ovf`=1 next cycle; the data drains as 01..08 only.
- With the FIFO full, push 8'hAA and pop in the same cycle.
  - Expected: `count` stays 8, head becomes 8'h02, 8'hAA is drained last.
  - `ovf` is unchanged.
- Run 20 cycles with `in_strobe` and `out_ready` both held high and an incrementing byte.
  - Expected: `count` settles at 1, output sequence is in order with no gaps.
  - This exercises pointer wrap past index 7→0.
- `flush` with `count`=5 and a simultaneous push of 8'h33.
  - Expected: next cycle `count`=0, `out_valid`=0; 8'h33 is not stored; `ovf` unchanged.
- Assert `rst` asynchronously mid-cycle with `count`=3 and `ovf`=1.
  - Expected: outputs reach reset values before the next edge.
  - Also, `ovf_clr` coincident with an overflow event leaves `ovf`=1.
